// File: rtl/adlv_pkg.sv
// Shared definitions for the adlv redundant-adder resolve stages:
// operand geometry, chunk count, FSM state type and the chunk lane mask.
package adlv_pkg;

   localparam int W      = 19;
   localparam int CHUNK  = 5;
   localparam int NCH    = (W + CHUNK - 1) / CHUNK;
   localparam int IDX_W  = $clog2(NCH);
   localparam int PADW   = NCH * CHUNK;
   localparam int LAST_W = W - (NCH - 1) * CHUNK;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Lanes of a chunk that carry real operand bits; the last chunk is
   // narrower than CHUNK, so its upper lanes are forced to zero.
   function automatic logic [CHUNK-1:0] chunk_mask(input logic [IDX_W-1:0] idx);
      logic [CHUNK-1:0] m;
      if (idx == IDX_W'(NCH - 1)) begin
         m = CHUNK'((1 << LAST_W) - 1);
      end else begin
         m = {CHUNK{1'b1}};
      end
      return m;
   endfunction

endpackage

// File: rtl/adlv_chunk_add.sv
// Combinational CW-bit adder slice with carry in/out, used once per cycle
// by the resolve stage to add one chunk of the redundant pair.
module adlv_chunk_add #(
   parameter int CW = 5
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
   output logic [CW-1:0] sum,
   output logic          cout
);

   logic [CW:0] total_s;

   assign total_s = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
   assign sum     = total_s[CW-1:0];
   assign cout    = total_s[CW];

endmodule

// File: rtl/adlv_resolve_19.sv
// Resolves one redundant (S, E) pair into the binary sum S + E, one chunk
// per cycle starting at the LSB chunk, with valid/ready on both sides.
module adlv_resolve_19
   import adlv_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_s,
   input  logic [W-1:0] in_e,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   out_res
);

   state_t             state_r;
   state_t             state_s;
   logic               in_ready_s;
   logic               accept_s;

   logic [W-1:0]       s_r;
   logic [W-1:0]       e_r;
   logic               carry_r;
   logic [IDX_W-1:0]   idx_r;
   logic [PADW-1:0]    res_r;
   logic               out_valid_r;

   logic [PADW-1:0]    s_pad_s;
   logic [PADW-1:0]    e_pad_s;
   logic [4:0]         base_s;
   logic [CHUNK-1:0]   mask_s;
   logic [CHUNK-1:0]   a_s;
   logic [CHUNK-1:0]   b_s;
   logic [CHUNK-1:0]   sum_s;
   logic               cout_s;

   // Select the active chunk of the latched operands; the masked top lane of
   // the last chunk receives the final carry, which lands on result bit W.
   assign s_pad_s = {{(PADW - W){1'b0}}, s_r};
   assign e_pad_s = {{(PADW - W){1'b0}}, e_r};
   assign base_s  = {3'b000, idx_r} * 5'(CHUNK);
   assign mask_s  = chunk_mask(idx_r);
   assign a_s     = s_pad_s[base_s +: CHUNK] & mask_s;
   assign b_s     = e_pad_s[base_s +: CHUNK] & mask_s;

   adlv_chunk_add #(
      .CW (CHUNK)
   ) u_chunk_add (
      .a    (a_s),
      .b    (b_s),
      .cin  (carry_r),
      .sum  (sum_s),
      .cout (cout_s)
   );

   // Next-state and input-side handshake decode.
   always_comb begin
      state_s    = state_r;
      in_ready_s = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready_s = 1'b1;
            if (in_valid) begin
               state_s = ADD;
            end else begin
               state_s = IDLE;
            end
         end
         ADD: begin
            if (idx_r == IDX_W'(NCH - 1)) begin
               state_s = DONE;
            end else begin
               state_s = ADD;
            end
         end
         DONE: begin
            // Result consumption and new acceptance share the same edge.
            in_ready_s = out_ready;
            if (out_ready && in_valid) begin
               state_s = ADD;
            end else if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      accept_s = in_valid & in_ready_s;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand capture, chunk-by-chunk result build-up and output valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_r         <= {W{1'b0}};
         e_r         <= {W{1'b0}};
         carry_r     <= 1'b0;
         idx_r       <= {IDX_W{1'b0}};
         res_r       <= {PADW{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         if (accept_s) begin
            s_r     <= in_s;
            e_r     <= in_e;
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
         end else if (state_r == ADD) begin
            res_r[base_s +: CHUNK] <= sum_s;
            carry_r                <= cout_s;
            idx_r                  <= idx_r + IDX_W'(1);
         end
         out_valid_r <= (state_s == DONE);
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_res   = res_r[W:0];

endmodule

// File: tb/tb_adlv_resolve_19.sv
// Self-checking bench for adlv_resolve_19: directed latency/boundary cases,
// backpressure, reset mid-transaction, then randomized traffic against a
// plain S+E scoreboard.
module tb_adlv_resolve_19;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [18:0] in_s = 19'h0;
   logic [18:0] in_e = 19'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [19:0] out_res;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   adlv_resolve_19 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_s      (in_s),
      .in_e      (in_e),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] ref_sum(input logic [18:0] a, input logic [18:0] b);
      return 20'(a) + 20'(b);
   endfunction

   // One transaction from idle with out_ready high: checks acceptance,
   // the 4-cycle latency window, the result and the return to idle.
   task automatic run_op(input string tag, input logic [18:0] s, input logic [18:0] e);
      logic [19:0] exp;
      exp = ref_sum(s, e);
      @(negedge clk);
      in_s = s; in_e = e; in_valid = 1'b1; out_ready = 1'b1;
      #1 check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0; in_s = 19'($urandom); in_e = 19'($urandom);
      #1 check_eq({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      repeat (2) @(negedge clk);
      #1 check_eq({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      #1 check_eq({tag, "_t3_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      #1;
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_res"}, 32'(out_res), 32'(exp));
      @(negedge clk);
      #1 check_eq({tag, "_consumed"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [19:0] q[$];
      logic        fire;
      int          sent;
      int          got;
      int          cyc;

      // Reset state
      #12;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_res", 32'(out_res), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_eq("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed arithmetic cases
      run_op("ripple", 19'h7FFFF, 19'h00001);
      run_op("mixed",  19'h12345, 19'h0ABCD);
      run_op("zeros",  19'h00000, 19'h00000);
      run_op("max",    19'h7FFFF, 19'h7FFFF);

      // Backpressure in DONE, then back-to-back acceptance
      @(negedge clk);
      in_s = 19'h55555; in_e = 19'h2AAAA; in_valid = 1'b1; out_ready = 1'b0;
      #1 check_eq("bp_accept", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk);
      #1;
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_res", 32'(out_res), 32'h7FFFF);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
         check_eq("bp_hold_res", 32'(out_res), 32'h7FFFF);
         check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_s = 19'h00100; in_e = 19'h00200;
      #1;
      check_eq("b2b_ready", 32'(in_ready), 32'd1);
      check_eq("b2b_res_old", 32'(out_res), 32'h7FFFF);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check_eq("b2b_valid_drop", 32'(out_valid), 32'd0);
      repeat (3) @(negedge clk);
      @(negedge clk);
      #1;
      check_eq("b2b_valid", 32'(out_valid), 32'd1);
      check_eq("b2b_res", 32'(out_res), 32'h00300);

      // Reset during ADD discards the transaction
      @(negedge clk);
      in_s = 19'h7FFFF; in_e = 19'h7FFFF; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rmid_valid", 32'(out_valid), 32'd0);
      check_eq("rmid_res", 32'(out_res), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rmid_in_ready", 32'(in_ready), 32'd1);
      check_eq("rmid_no_valid", 32'(out_valid), 32'd0);
      run_op("after_rst", 19'h00010, 19'h00020);

      // Randomized traffic against the S+E scoreboard
      fire = 1'b0; sent = 0; got = 0; cyc = 0;
      while (got < 1000 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (fire) begin
            in_valid = 1'b0;
         end
         fire = 1'b0;
         if (!in_valid) begin
            if (sent < 1000 && $urandom_range(0, 2) != 0) begin
               in_valid = 1'b1;
               case ($urandom_range(0, 5))
                  0: in_s = 19'h7FFFF;
                  1: in_s = 19'h00000;
                  default: in_s = 19'($urandom);
               endcase
               case ($urandom_range(0, 5))
                  0: in_e = 19'h7FFFF;
                  1: in_e = 19'h00001;
                  default: in_e = 19'($urandom);
               endcase
            end else begin
               in_s = 19'($urandom);
               in_e = 19'($urandom);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (in_valid && in_ready) begin
            q.push_back(ref_sum(in_s, in_e));
            sent++;
            fire = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check_eq("rnd_dup", 32'd1, 32'd0);
            end else begin
               check_eq("rnd_res", 32'(out_res), 32'(q.pop_front()));
               got++;
            end
         end
      end
      check_eq("rnd_count", 32'(got), 32'd1000);
      check_eq("rnd_left", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
